// File: rtl/fpnew_divsqrt_wb_buffer_if.sv
// fpnew_divsqrt_wb_buffer_if: handshake, data and status bundle between the div/sqrt unit, the result buffer and writeback.
interface fpnew_divsqrt_wb_buffer_if #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned TAG_WIDTH = 8
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_result;
    logic [4:0]                 in_status;
    logic [2:0]                 in_fmt;
    logic [TAG_WIDTH-1:0]       in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_result;
    logic [4:0]                 out_status;
    logic [TAG_WIDTH-1:0]       out_tag;
    logic [4:0]                 fflags;
    logic                       fflags_clr;
    logic [$clog2(DEPTH):0]     count;
    logic                       busy;

    modport master (
        output flush, in_valid, in_result, in_status, in_fmt, in_tag, out_ready, fflags_clr,
        input  in_ready, out_valid, out_result, out_status, out_tag, fflags, count, busy
    );

    modport slave (
        input  flush, in_valid, in_result, in_status, in_fmt, in_tag, out_ready, fflags_clr,
        output in_ready, out_valid, out_result, out_status, out_tag, fflags, count, busy
    );
endinterface

// File: rtl/fpnew_divsqrt_wb_buffer.sv
// fpnew_divsqrt_wb_buffer: result FIFO behind the div/sqrt unit.
// It NaN-boxes narrow formats on the way out and keeps sticky IEEE flags.
module fpnew_divsqrt_wb_buffer #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned TAG_WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst,
    fpnew_divsqrt_wb_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0]     mem_result [DEPTH];
    logic [4:0]           mem_status [DEPTH];
    logic [2:0]           mem_fmt    [DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count_q;
    logic [4:0]           fflags_q;
    logic                 push, pop;
    logic [2:0]           head_fmt;
    logic [6:0]           fw;
    logic [WIDTH-1:0]     box_mask;

    // Ready depends only on registered occupancy, so a full buffer never takes a push even when popping.
    assign bus.in_ready  = count_q < CW'(DEPTH);
    assign bus.out_valid = (count_q != '0) && !bus.flush;
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.count     = count_q;
    assign bus.busy      = count_q != '0;
    assign bus.fflags    = fflags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= bus.in_result;
            mem_status[wr_ptr] <= bus.in_status;
            mem_fmt[wr_ptr]    <= bus.in_fmt;
            mem_tag[wr_ptr]    <= bus.in_tag;
        end
    end

    // A clear coinciding with a pop restarts accumulation from that pop's flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fflags_q <= '0;
        else if (pop) fflags_q <= (bus.fflags_clr ? 5'b0 : fflags_q) | bus.out_status;
        else if (bus.fflags_clr) fflags_q <= '0;
    end

    // fw of 0 marks the reserved formats, which pass through unboxed.
    assign head_fmt = mem_fmt[rd_ptr];
    assign fw = head_fmt == 3'd0 ? 7'd32 :
                head_fmt == 3'd1 ? 7'd64 :
                (head_fmt == 3'd2 || head_fmt == 3'd4) ? 7'd16 :
                head_fmt == 3'd3 ? 7'd8 : 7'd0;

    always_comb begin
        box_mask = '0;
        for (int i = 0; i < WIDTH; i++) box_mask[i] = (fw != 7'd0) && (i >= int'(fw));
    end

    assign bus.out_result = mem_result[rd_ptr] | box_mask;
    assign bus.out_status = mem_status[rd_ptr];
    assign bus.out_tag    = mem_tag[rd_ptr];
endmodule

// File: tb/tb_fpnew_divsqrt_wb_buffer.sv
// tb_fpnew_divsqrt_wb_buffer: vector table for boxing and flags, plus directed backpressure, wrap, flush and reset sequences.
module tb_fpnew_divsqrt_wb_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    fpnew_divsqrt_wb_buffer_if #(.WIDTH(64), .DEPTH(2), .TAG_WIDTH(8)) bus ();

    fpnew_divsqrt_wb_buffer #(.WIDTH(64), .DEPTH(2), .TAG_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] result;
        logic [4:0]  status;
        logic [7:0]  tag;
        logic [63:0] exp_result;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [7:0] tag, input logic [4:0] status);
        bus.in_valid  = 1'b1;
        bus.in_tag    = tag;
        bus.in_status = status;
        bus.in_fmt    = 3'd1;
        bus.in_result = {56'h0, tag};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp_ff;
        int next_tag;
        int exp_tag;
        vecs[0] = '{3'd0, 64'h0000_0000_3F80_0000, 5'b00001, 8'h5A, 64'hFFFF_FFFF_3F80_0000};
        vecs[1] = '{3'd3, 64'h0000_0000_0000_003C, 5'b00000, 8'h31, 64'hFFFF_FFFF_FFFF_FF3C};
        vecs[2] = '{3'd1, 64'h4000_0000_0000_0000, 5'b01000, 8'h32, 64'h4000_0000_0000_0000};
        vecs[3] = '{3'd6, 64'h0000_0000_0000_1234, 5'b00000, 8'h33, 64'h0000_0000_0000_1234};
        vecs[4] = '{3'd2, 64'h0000_0000_0000_3C00, 5'b00010, 8'h34, 64'hFFFF_FFFF_FFFF_3C00};
        vecs[5] = '{3'd4, 64'h0000_0000_0000_3F80, 5'b00000, 8'h35, 64'hFFFF_FFFF_FFFF_3F80};
        vecs[6] = '{3'd7, 64'hDEAD_BEEF_0000_0001, 5'b10000, 8'h36, 64'hDEAD_BEEF_0000_0001};

        bus.flush = 0; bus.in_valid = 0; bus.in_result = '0; bus.in_status = '0;
        bus.in_fmt = '0; bus.in_tag = '0; bus.out_ready = 0; bus.fflags_clr = 0;

        tick(); tick();
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fflags", bus.fflags, 0);
        rst = 0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Format boxing / single-entry latency table
        exp_ff = 5'b0;
        bus.out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid  = 1;
            bus.in_fmt    = vecs[i].fmt;
            bus.in_result = vecs[i].result;
            bus.in_status = vecs[i].status;
            bus.in_tag    = vecs[i].tag;
            tick();
            bus.in_valid = 0;
            #1;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_result", i), bus.out_result, vecs[i].exp_result);
            chk($sformatf("vec%0d_tag", i), bus.out_tag, vecs[i].tag);
            chk($sformatf("vec%0d_status", i), bus.out_status, vecs[i].status);
            tick();
            exp_ff = exp_ff | vecs[i].status;
            chk($sformatf("vec%0d_fflags", i), bus.fflags, exp_ff);
            chk($sformatf("vec%0d_empty", i), bus.out_valid, 0);
        end

        // Fill and backpressure
        bus.out_ready = 0;
        drive_push(8'h11, 5'b0);
        tick();
        chk("fill_count1", bus.count, 1);
        drive_push(8'h12, 5'b0);
        tick();
        chk("fill_count2", bus.count, 2);
        chk("fill_in_ready", bus.in_ready, 0);
        chk("fill_busy", bus.busy, 1);
        drive_push(8'h13, 5'b0);
        tick();
        chk("fill_held_count", bus.count, 2);
        bus.in_valid = 0;
        bus.out_ready = 1;
        #1;
        chk("fill_head0", bus.out_tag, 8'h11);
        tick();
        chk("fill_drain_count1", bus.count, 1);
        chk("fill_head1", bus.out_tag, 8'h12);
        tick();
        chk("fill_drain_count0", bus.count, 0);
        chk("fill_drain_valid", bus.out_valid, 0);

        // Wrap-around with random downstream readiness
        next_tag = 1;
        exp_tag = 1;
        for (int c = 0; c < 300 && exp_tag <= 7; c++) begin
            if (next_tag <= 7) drive_push(8'(next_tag), 5'b0);
            else bus.in_valid = 0;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) next_tag++;
            if (bus.out_valid && bus.out_ready) begin
                chk("wrap_tag", bus.out_tag, 8'(exp_tag));
                exp_tag++;
            end
            tick();
        end
        bus.in_valid = 0;
        bus.out_ready = 0;
        chk("wrap_received", exp_tag, 8);
        chk("wrap_count", bus.count, 0);

        // Sticky flags: clear alone, accumulate, clear together with a pop
        bus.fflags_clr = 1;
        tick();
        bus.fflags_clr = 0;
        chk("flags_clr_alone", bus.fflags, 0);
        drive_push(8'h51, 5'b10000);
        tick();
        drive_push(8'h52, 5'b00100);
        tick();
        bus.in_valid = 0;
        bus.out_ready = 1;
        tick();
        tick();
        chk("flags_accum", bus.fflags, 5'b10100);
        bus.out_ready = 0;
        drive_push(8'h53, 5'b00010);
        tick();
        bus.in_valid = 0;
        bus.fflags_clr = 1;
        bus.out_ready = 1;
        tick();
        bus.fflags_clr = 0;
        bus.out_ready = 0;
        chk("flags_clr_pop", bus.fflags, 5'b00010);
        chk("flags_count", bus.count, 0);

        // Flush with a full buffer and a pending push
        drive_push(8'h21, 5'b01000);
        tick();
        drive_push(8'h22, 5'b01000);
        tick();
        drive_push(8'h23, 5'b01000);
        bus.flush = 1;
        bus.out_ready = 1;
        #1;
        chk("flush_valid_low", bus.out_valid, 0);
        tick();
        bus.flush = 0;
        bus.in_valid = 0;
        chk("flush_count", bus.count, 0);
        chk("flush_busy", bus.busy, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_fflags", bus.fflags, 5'b00010);

        // Flush while a push would otherwise be accepted
        bus.out_ready = 0;
        drive_push(8'h24, 5'b0);
        tick();
        drive_push(8'h25, 5'b0);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        bus.in_valid = 0;
        tick();
        chk("flush_push_dropped", bus.count, 0);
        chk("flush_push_no_out", bus.out_valid, 0);

        // Asynchronous reset mid-operation
        drive_push(8'h41, 5'b0);
        tick();
        bus.in_valid = 0;
        chk("arst_pre_count", bus.count, 1);
        rst = 1;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_fflags", bus.fflags, 0);
        tick();
        rst = 0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpnew_divsqrt_wb_buffer.md
# fpnew_divsqrt_wb_buffer

Result buffer directly downstream of the multi-format divide/square-root unit. It accepts completed results through a valid/ready handshake and stores them in a small FIFO, so a stalled writeback port never holds the iterative unit in its HOLD state. On the way out it NaN-boxes narrow-format results to the full register width and accumulates IEEE status flags into a sticky flag register.

## Interface
- WIDTH, 64, result width in bits; 16..64.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- TAG_WIDTH, 8, width of the opaque tag carried with each result.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush of all buffered entries.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  buffer can accept an entry.
- result_i  in  WIDTH  raw result; narrow formats are right-aligned.
- status_i  in  5  flags {NV,DZ,OF,UF,NX}.
- fmt_i  in  3  destination format: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT.
- tag_i  in  TAG_WIDTH  opaque tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- result_o  out  WIDTH  NaN-boxed head result.
- status_o  out  5  head flags.
- tag_o  out  TAG_WIDTH  head tag.
- fflags_o  out  5  sticky OR of all popped status values.
- fflags_clr_i  in  1  clear sticky flags.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- busy_o  out  1  count_o != 0.

## Operation
- Storage: DEPTH entries of {result, status, fmt, tag}. Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. A separate count register is kept.
- Push occurs when in_valid_i && in_ready_o && !flush_i. Pop occurs when out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH). It is a registered-state function with no combinational path from out_ready_i. When the buffer is full, a same-cycle pop does not enable a push.
- out_valid_o = (count != 0) && !flush_i. There is no fall-through.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- NaN-boxing is applied on the output path only. The format width is 32/64/16/8/16 for fmt 0/1/2/3/4. Bits [WIDTH-1:fw] of result_o are forced to 1 when fw < WIDTH. When fw ≥ WIDTH, or for fmt 5..7, the stored result passes through unchanged.
- Sticky flags: on each pop, fflags_q |= status_o.
  - fflags_clr_i alone sets fflags_q to 0.
  - fflags_clr_i together with a pop sets fflags_q to the popped status_o, so that pop's flags are not lost.
- Flush clears the pointers and count on the next edge. Any push in the flush cycle is discarded, and no pop occurs in the flush cycle. fflags_q is not affected by flush.
- Reset values: pointers = 0, count_o = 0, fflags_o = 0, out_valid_o = 0, in_ready_o = 1, busy_o = 0. Entry storage is not reset. result_o, status_o and tag_o are don't-care while out_valid_o = 0.
- Asserting rst_i mid-operation drops all entries immediately, asynchronously.

## Timing
- Push in cycle N makes the entry visible at the head (out_valid_o = 1) in cycle N+1. Minimum latency is 1 cycle.
- Throughput is 1 entry per cycle when out_ready_i is held high and the buffer is not full.
- Results leave in push order (FIFO).
- count_o, in_ready_o and busy_o update on the edge following the event.
- fflags_o reflects a pop in the cycle after the pop.
- flush_i asserted in cycle N: out_valid_o = 0 in cycle N, count_o = 0 from N+1.
- Release of rst_i: in_ready_o = 1 in the first cycle after release.

## Test plan
- Single FP32 entry:
  - Stimulus: push result 0x0000_0000_3F80_0000, fmt 0, status 0b00001, tag 0x5A; hold out_ready_i = 1.
  - Required: next cycle out_valid_o = 1, result_o = 0xFFFF_FFFF_3F80_0000, tag_o = 0x5A; the cycle after, fflags_o = 0b00001.
- Fill and backpressure:
  - Stimulus: out_ready_i = 0, push 3 entries with DEPTH = 2.
  - Required: the third entry is held off (in_ready_o = 0 after 2 pushes, count_o = 2). After out_ready_i = 1, entries leave in order; count_o goes 2 → 1 → 0.
- Wrap-around:
  - Stimulus: push and pop 7 entries with tags 1..7 and random out_ready_i.
  - Required: tags are observed 1..7 in order; no loss or duplication.
- Flags:
  - Stimulus: pop entries with status 0b10000 then 0b00100; then assert fflags_clr_i in the same cycle as a pop with status 0b00010.
  - Required: fflags_o = 0b10100, then 0b00010.
- Flush:
  - Stimulus: fill 2 entries, assert flush_i together with a push.
  - Required: out_valid_o = 0 that cycle, count_o = 0 next cycle, the pushed entry is never output, fflags_o is unchanged.
- Format boxing:
  - Stimulus: FP8 result 0x3C, FP64 result 0x4000_0000_0000_0000, fmt 6 result 0x1234.
  - Required: outputs 0xFFFF_FFFF_FFFF_FF3C, 0x4000_0000_0000_0000, 0x0000_0000_0000_1234.
